pll_lock_supervisor: RTL and testbench

// - Supervises the board PLL from the 25 MHz reference clock: pulses the PLL reset, waits for lock,

---
 rtl/pll_lock_supervisor.sv | 133 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies lock, gates the system reset.
// Optional build macro PLL_SUP_GLITCH_FILTER_EN adds a lock-low persistence filter in RUN.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 25000,
  parameter int unsigned STABLE_CYCLES = 2500,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned GLITCH_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk25_i,
  input  logic       rstn_i,
  input  logic       locked_i,
  output logic       pll_rst_o,
  output logic       sys_rst_n_o,
  output logic       lock_lost_o,
  output logic       fault_o,
  output logic [3:0] retries_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFault    = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       MaxRetries  = 4'(MAX_RETRIES);
`ifdef PLL_SUP_GLITCH_FILTER_EN
  localparam logic [CNT_W-1:0] GlitchLast  = CNT_W'(GLITCH_CYCLES - 1);
`else
  logic unused_glitch_cycles;
  assign unused_glitch_cycles = ^GLITCH_CYCLES;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retries_q, retries_d, retries_inc;
  logic             lock_meta_q, lock_s_q;
  logic             pll_rst_q, sys_rst_n_q, lock_lost_q, fault_q;

  // locked_i is asynchronous to clk25_i
  always_ff @(posedge clk25_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= locked_i;
      lock_s_q    <= lock_meta_q;
    end
  end

  assign retries_inc = (retries_q == 4'hF) ? 4'hF : retries_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    case (state_q)
      StPllRst: begin
        if (cnt_q == RstLast) state_d = StWaitLock;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      StWaitLock: begin
        if (lock_s_q) begin
          state_d = StStable;
        end else if (cnt_q == TimeoutLast) begin
          retries_d = retries_inc;
          state_d   = (retries_inc == MaxRetries) ? StFault : StPllRst;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStable: begin
        if (!lock_s_q)               state_d = StWaitLock;
        else if (cnt_q == StableLast) state_d = StRun;
        else                          cnt_d   = cnt_q + 1'b1;
      end
      StRun: begin
`ifdef PLL_SUP_GLITCH_FILTER_EN
        // cnt_q tracks the current run of consecutive lock-low samples
        if (lock_s_q)                 cnt_d   = '0;
        else if (cnt_q == GlitchLast) state_d = StPllRst;
        else                          cnt_d   = cnt_q + 1'b1;
`else
        if (!lock_s_q) state_d = StPllRst;
`endif
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StPllRst;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
    if ((state_d == StRun) && (state_q != StRun)) retries_d = '0;
  end

  // Outputs are registered from the next state so they change on the transition edge
  always_ff @(posedge clk25_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StPllRst;
      cnt_q       <= '0;
      retries_q   <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lock_lost_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      pll_rst_q   <= (state_d == StPllRst);
      sys_rst_n_q <= (state_d == StRun);
      lock_lost_q <= (state_q == StRun) && (state_d == StPllRst);
      fault_q     <= (state_d == StFault);
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign sys_rst_n_o = sys_rst_n_q;
  assign lock_lost_o = lock_lost_q;
  assign fault_o     = fault_q;
  assign retries_o   = retries_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: phase/elapsed-time reference model checked every
// cycle, directed scenarios with literal expectations, then randomized lock behaviour.
module tb_pll_lock_supervisor;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 3;
  localparam int GC = 3;

  logic       clk25;
  logic       rstn_i;
  logic       locked_i;
  logic       pll_rst_o;
  logic       sys_rst_n_o;
  logic       lock_lost_o;
  logic       fault_o;
  logic [3:0] retries_o;
  logic [2:0] state_o;

  pll_lock_supervisor #(
    .RST_CYCLES   (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR),
    .GLITCH_CYCLES(GC),
    .CNT_W        (16)
  ) dut (
    .clk25_i    (clk25),
    .rstn_i     (rstn_i),
    .locked_i   (locked_i),
    .pll_rst_o  (pll_rst_o),
    .sys_rst_n_o(sys_rst_n_o),
    .lock_lost_o(lock_lost_o),
    .fault_o    (fault_o),
    .retries_o  (retries_o),
    .state_o    (state_o)
  );

  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  int checks;
  int errors;
  int cyc;

  // Reference model: phase 0..4 plus the edge index at which the phase was entered
  int m_phase;
  int m_entry;
  int m_retries;
  int m_low;
  bit m_lost;
  bit hist[$];

  function automatic void model_reset();
    m_phase   = 0;
    m_entry   = 0;
    m_retries = 0;
    m_low     = 0;
    m_lost    = 1'b0;
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
  endfunction

  function automatic void model_step();
    bit ls;
    int el;
    int nxt;
    if (!rstn_i) begin
      model_reset();
      return;
    end
    ls = hist.pop_front();
    hist.push_back(locked_i);
    el     = cyc - m_entry;
    nxt    = m_phase;
    m_lost = 1'b0;
    case (m_phase)
      0: if (el == RC) nxt = 1;
      1: begin
        if (ls) nxt = 2;
        else if (el == LT) begin
          if (m_retries < 15) m_retries++;
          nxt = (m_retries == MR) ? 4 : 0;
        end
      end
      2: begin
        if (!ls) nxt = 1;
        else if (el == SC) nxt = 3;
      end
      3: begin
`ifdef PLL_SUP_GLITCH_FILTER_EN
        if (ls) m_low = 0;
        else begin
          m_low++;
          if (m_low == GC) nxt = 0;
        end
`else
        if (!ls) nxt = 0;
`endif
      end
      default: nxt = m_phase;
    endcase
    if (nxt != m_phase) begin
      if (nxt == 3) m_retries = 0;
      if (m_phase == 3 && nxt == 0) m_lost = 1'b1;
      m_entry = cyc;
      m_low   = 0;
      m_phase = nxt;
    end
  endfunction

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // One clock: model steps on the edge, outputs compared on the falling edge
  task automatic tick();
    logic [10:0] exp_v;
    logic [10:0] got_v;
    @(posedge clk25);
    if (!rstn_i) cyc = 0;
    else         cyc++;
    model_step();
    @(negedge clk25);
    if (rstn_i) begin
      exp_v = {m_phase == 0, m_phase == 3, m_lost, m_phase == 4, 4'(m_retries), 3'(m_phase)};
      got_v = {pll_rst_o, sys_rst_n_o, lock_lost_o, fault_o, retries_o, state_o};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL model cycle %0d: got %b required %b", cyc, got_v, exp_v);
      end
    end
    #1;
  endtask

  task automatic check_reset_vals(input string name);
    check(name, int'({pll_rst_o, sys_rst_n_o, lock_lost_o, fault_o, retries_o, state_o}),
          int'(11'b1000_0000_000));
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    model_reset();
    tick();
    tick();
    check_reset_vals("reset_values");
    rstn_i = 1'b1;
  endtask

  // Mid-cycle asynchronous reset: outputs must collapse before the next edge
  task automatic async_reset_pulse(input string name);
    #2 rstn_i = 1'b0;
    #1 check_reset_vals(name);
    model_reset();
    tick();
    tick();
    rstn_i = 1'b1;
  endtask

  task automatic wait_state(input int s, input int budget);
    int n;
    n = 0;
    while (state_o !== 3'(s) && n < budget) begin
      tick();
      n++;
    end
    check("reach_state", int'(state_o), s);
  endtask

  int c0;
  int n;
  int pulses;
  int lost_at;
  int pll_hi;
  int sys_lo;
  int r30;
  int r50;
  int run;
  int rst_at;

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    rstn_i   = 1'b0;
    locked_i = 1'b0;
    model_reset();

    // Nominal bring-up
    do_reset();
    n = 0;
    while (pll_rst_o && n < 50) begin
      tick();
      n++;
    end
    check("pll_rst_width", cyc, 4);
    repeat (10) tick();
    locked_i = 1'b1;
    c0 = cyc;
    while (!sys_rst_n_o && cyc - c0 < 40) tick();
    check("release_latency", cyc - c0, 11);
    check("retries_after_nominal", int'(retries_o), 0);

    // Loss of lock while running
`ifdef PLL_SUP_GLITCH_FILTER_EN
    locked_i = 1'b0;
    tick();
    tick();
    locked_i = 1'b1;
    pulses = 0;
    sys_lo = 0;
    repeat (20) begin
      tick();
      if (lock_lost_o) pulses++;
      if (!sys_rst_n_o) sys_lo++;
    end
    check("glitch2_lost_pulses", pulses, 0);
    check("glitch2_sys_low", sys_lo, 0);
    locked_i = 1'b0;
    c0 = cyc;
    repeat (3) tick();
    locked_i = 1'b1;
    pulses  = 0;
    lost_at = -1;
    pll_hi  = 0;
    repeat (30) begin
      if (lock_lost_o) begin
        pulses++;
        if (lost_at < 0) lost_at = cyc;
        check("sys_low_at_loss", int'(sys_rst_n_o), 0);
      end
      if (pll_rst_o) pll_hi++;
      tick();
    end
    check("loss_pulses", pulses, 1);
    check("loss_latency", lost_at - c0, 5);
    check("loss_pll_rst_width", pll_hi, 4);
`else
    locked_i = 1'b0;
    c0 = cyc;
    tick();
    locked_i = 1'b1;
    pulses  = 0;
    lost_at = -1;
    pll_hi  = 0;
    repeat (30) begin
      if (lock_lost_o) begin
        pulses++;
        if (lost_at < 0) lost_at = cyc;
        check("sys_low_at_loss", int'(sys_rst_n_o), 0);
      end
      if (pll_rst_o) pll_hi++;
      tick();
    end
    check("loss_pulses", pulses, 1);
    check("loss_latency", lost_at - c0, 3);
    check("loss_pll_rst_width", pll_hi, 4);
`endif
    wait_state(3, 40);

    // Lock bounce during qualification
    locked_i = 1'b0;
    do_reset();
    n = 0;
    while (pll_rst_o && n < 50) begin
      tick();
      n++;
    end
    locked_i = 1'b1;
    repeat (5) tick();
    locked_i = 1'b0;
    tick();
    locked_i = 1'b1;
    c0 = cyc;
    while (!sys_rst_n_o && cyc - c0 < 40) tick();
    check("bounce_release_latency", cyc - c0, 11);
    check("bounce_retries", int'(retries_o), 0);

    // Repeated timeouts end in FAULT
    locked_i = 1'b0;
    do_reset();
    r30 = -1;
    r50 = -1;
    while (!fault_o && cyc < 150) begin
      tick();
      if (cyc == 30) r30 = int'(retries_o);
      if (cyc == 50) r50 = int'(retries_o);
    end
    check("retries_first", r30, 1);
    check("retries_second", r50, 2);
    check("fault_cycle", cyc, 72);
    check("fault_state", int'(state_o), 4);
    check("fault_retries", int'(retries_o), 3);
    locked_i = 1'b1;
    repeat (30) tick();
    check("fault_sticky", int'({fault_o, pll_rst_o, sys_rst_n_o, state_o}), int'(6'b100_100));

    // Asynchronous reset while qualifying lock
    locked_i = 1'b1;
    do_reset();
    wait_state(2, 20);
    repeat (3) tick();
    async_reset_pulse("async_reset_in_stable");
    repeat (20) tick();
    check("relock_after_async_reset", int'(sys_rst_n_o), 1);

    // Randomized lock behaviour
    for (int ep = 0; ep < 24; ep++) begin
      locked_i = 1'($urandom_range(0, 1));
      do_reset();
      rst_at = (ep % 4 == 3) ? int'($urandom_range(50, 250)) : -1;
      run = 0;
      for (int t = 0; t < 300; t++) begin
        if (run == 0) begin
          locked_i = ~locked_i;
          n = int'($urandom_range(0, 9));
          if (n < 3)      run = int'($urandom_range(1, 3));
          else if (n < 6) run = int'($urandom_range(4, 15));
          else            run = int'($urandom_range(20, 60));
        end
        run--;
        if (t == rst_at) async_reset_pulse("async_reset_random");
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
